spi_regfile_ctrl: RTL and testbench

//  Transaction controller for spi_slave. Sequences its byte-request handshake into a framed register protocol.

---
 rtl/spi_regfile_ctrl_if.sv | 26 ++
 rtl/spi_regfile_ctrl.sv | 131 +++++++++++++
 tb/tb_spi_regfile_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_ctrl_if.sv
// Bus bundle between spi_regfile_ctrl and its neighbours: the spi_slave
// byte handshake, the local fabric register port and the write strobe.
interface spi_regfile_ctrl_if;
  logic       select;
  logic       request;
  logic [7:0] dout;
  logic [7:0] din;
  logic [6:0] loc_addr;
  logic [7:0] loc_rdata;
  logic       loc_we;
  logic [7:0] loc_wdata;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  modport slave (
    input  select, request, dout, loc_addr, loc_we, loc_wdata,
    output din, loc_rdata, wr_stb, wr_addr, wr_data, busy
  );

  modport master (
    output select, request, dout, loc_addr, loc_we, loc_wdata,
    input  din, loc_rdata, wr_stb, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/spi_regfile_ctrl.sv
// Framed SPI register protocol on top of spi_slave's byte handshake.
// First byte of a frame is the command (bit7 write, bits[6:0] start address),
// following bytes are data with auto-incrementing address.
//
//  state | meaning
//  IDLE  | no frame, waiting for the frame-start request
//  CMD   | signature is being shifted out, command byte coming in
//  WDATA | write frame, each byte commits at addr then addr+1
//  RDATA | read frame, din prefetches the next address each byte
module spi_regfile_ctrl #(
  parameter int         DEPTH     = 32,
  parameter logic [7:0] SIGNATURE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_regfile_ctrl_if.slave bus
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t     state, state_nxt;
  logic [6:0] addr;
  logic [7:0] mem [DEPTH];

  logic       hit;
  logic [6:0] addr_inc;
  logic       addr_ok, next_ok, cmd_ok, loc_ok;
  logic [7:0] rd_cmd, rd_next;
  logic       ld_sig, ld_cmd, wstep, rstep;
  logic       spi_we, loc_commit, same_addr;

  assign hit       = bus.select && bus.request;
  assign addr_inc  = addr + 7'd1;
  assign addr_ok   = ({1'b0, addr}          < DEPTH_B);
  assign next_ok   = ({1'b0, addr_inc}      < DEPTH_B);
  assign cmd_ok    = ({1'b0, bus.dout[6:0]} < DEPTH_B);
  assign loc_ok    = ({1'b0, bus.loc_addr}  < DEPTH_B);
  assign rd_cmd    = cmd_ok  ? mem[bus.dout[AW-1:0]] : 8'hFF;
  assign rd_next   = next_ok ? mem[addr_inc[AW-1:0]] : 8'hFF;
  assign same_addr = (bus.loc_addr == addr);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: losing select aborts any frame, requests advance it
  always_comb begin
    state_nxt = state;
    if (!bus.select) begin
      state_nxt = IDLE;
    end else if (bus.request) begin
      case (state)
        IDLE:    state_nxt = CMD;
        CMD:     state_nxt = bus.dout[7] ? WDATA : RDATA;
        WDATA:   state_nxt = WDATA;
        RDATA:   state_nxt = RDATA;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-state datapath controls; SPI write beats a local write to the same address
  always_comb begin
    ld_sig = 1'b0;
    ld_cmd = 1'b0;
    wstep  = 1'b0;
    rstep  = 1'b0;
    if (hit) begin
      case (state)
        IDLE:    ld_sig = 1'b1;
        CMD:     ld_cmd = 1'b1;
        WDATA:   wstep  = 1'b1;
        RDATA:   rstep  = 1'b1;
        default: ;
      endcase
    end
    spi_we     = wstep && addr_ok;
    loc_commit = bus.loc_we && loc_ok && !(spi_we && same_addr);
    bus.busy   = (state != IDLE);
  end

  // Shift byte, address pointer, write strobe and registered local read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.din       <= 8'h00;
      addr          <= 7'd0;
      bus.wr_stb    <= 1'b0;
      bus.wr_addr   <= 7'd0;
      bus.wr_data   <= 8'h00;
      bus.loc_rdata <= 8'h00;
    end else begin
      bus.wr_stb <= spi_we;
      if (spi_we) begin
        bus.wr_addr <= addr;
        bus.wr_data <= bus.dout;
      end
      if (ld_sig) begin
        bus.din <= SIGNATURE;
      end else if (ld_cmd) begin
        addr    <= bus.dout[6:0];
        bus.din <= bus.dout[7] ? 8'h00 : rd_cmd;
      end else if (wstep) begin
        addr    <= addr_inc;
        bus.din <= 8'h00;
      end else if (rstep) begin
        addr    <= addr_inc;
        bus.din <= rd_next;
      end
      if (!loc_ok)                 bus.loc_rdata <= 8'hFF;
      else if (spi_we && same_addr) bus.loc_rdata <= bus.dout;
      else if (bus.loc_we)          bus.loc_rdata <= bus.loc_wdata;
      else                          bus.loc_rdata <= mem[bus.loc_addr[AW-1:0]];
    end
  end

  // Register array; the two write ports never hit the same entry in one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (spi_we)     mem[addr[AW-1:0]]         <= bus.dout;
      if (loc_commit) mem[bus.loc_addr[AW-1:0]] <= bus.loc_wdata;
    end
  end

endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Self-checking bench for spi_regfile_ctrl with a behavioural spi_slave
// handshake and a queue of expected write strobes.
module tb_spi_regfile_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_regfile_ctrl_if bus();

  spi_regfile_ctrl #(.DEPTH(32), .SIGNATURE(8'hA5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];

  // Collect every strobe the DUT produces
  always @(negedge clk) begin
    if (reset_n && bus.wr_stb) obs_q.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    bus.select = 1'b1;
    idle(2);
    bus.request = 1'b1;
    idle(1);
    bus.request = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mosi, output logic [7:0] miso);
    idle(3);
    miso = bus.din;
    bus.dout = mosi;
    bus.request = 1'b1;
    idle(1);
    bus.request = 1'b0;
    bus.dout = 8'h00;
  endtask

  task automatic frame_end();
    idle(2);
    bus.select = 1'b0;
    idle(2);
  endtask

  task automatic loc_wr(input logic [6:0] a, input logic [7:0] d);
    bus.loc_addr = a;
    bus.loc_wdata = d;
    bus.loc_we = 1'b1;
    idle(1);
    bus.loc_we = 1'b0;
  endtask

  task automatic loc_rd(input logic [6:0] a, output logic [7:0] d);
    bus.loc_addr = a;
    idle(2);
    d = bus.loc_rdata;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(2);
    n_checks++;
    if ({bus.busy, bus.din, bus.loc_rdata, bus.wr_stb, bus.wr_addr, bus.wr_data} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b din=%h rdata=%h stb=%b waddr=%h wdata=%h want all zero",
               bus.busy, bus.din, bus.loc_rdata, bus.wr_stb, bus.wr_addr, bus.wr_data);
    end
    reset_n = 1'b1;
    idle(2);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b din=%h want 0/00", bus.busy, bus.din);
    end
  endtask

  task automatic test_no_select();
    logic [7:0] d;
    bus.select = 1'b0;
    foreach (exp_q[i]) exp_q.delete(i);
    for (int i = 0; i < 2; i++) begin
      idle(3);
      bus.dout = (i == 0) ? 8'h81 : 8'h55;
      bus.request = 1'b1;
      idle(1);
      bus.request = 1'b0;
      idle(1);
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_select_busy: got %b want 0", bus.busy);
      end
    end
    idle(2);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL no_select_stb: got %0d strobes want 0", obs_q.size());
    end
    obs_q.delete();
    loc_rd(7'd1, d);
    n_checks++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL no_select_mem1: got %h want 00", d);
    end
  endtask

  task automatic test_write();
    logic [7:0] m, d;
    logic [7:0] want_m [3] = '{8'hA5, 8'h00, 8'h00};
    logic [7:0] mosi   [3] = '{8'h83, 8'h11, 8'h22};
    frame_begin();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) exp_q.push_back({7'(3 + i - 1), mosi[i]});
      xfer(mosi[i], m);
      n_checks++;
      if (m !== want_m[i]) begin
        n_fail++;
        $display("FAIL write_miso%0d: got %h want %h", i, m, want_m[i]);
      end
    end
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_busy: got %b want 1", bus.busy);
    end
    frame_end();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL write_stb_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL write_stb: got (%h,%h) want (%h,%h)", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    loc_rd(7'd3, d);
    n_checks++;
    if (d !== 8'h11) begin n_fail++; $display("FAIL write_mem3: got %h want 11", d); end
    loc_rd(7'd4, d);
    n_checks++;
    if (d !== 8'h22) begin n_fail++; $display("FAIL write_mem4: got %h want 22", d); end
  endtask

  task automatic test_read();
    logic [7:0] m;
    logic [7:0] want_m [3] = '{8'hA5, 8'hC3, 8'h3C};
    loc_wr(7'd5, 8'hC3);
    loc_wr(7'd6, 8'h3C);
    frame_begin();
    for (int i = 0; i < 3; i++) begin
      xfer((i == 0) ? 8'h05 : 8'h00, m);
      n_checks++;
      if (m !== want_m[i]) begin
        n_fail++;
        $display("FAIL read_miso%0d: got %h want %h", i, m, want_m[i]);
      end
    end
    frame_end();
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_stb: got %0d strobes want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_out_of_range();
    logic [7:0] m, d;
    logic [7:0] want_m [3] = '{8'hA5, 8'hAA, 8'hFF};
    frame_begin();
    xfer(8'h9F, m);
    exp_q.push_back({7'd31, 8'hAA});
    xfer(8'hAA, m);
    xfer(8'hBB, m);
    xfer(8'hCC, m);
    frame_end();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL oor_stb_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL oor_stb: got (%h,%h) want (%h,%h)", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    frame_begin();
    for (int i = 0; i < 3; i++) begin
      xfer((i == 0) ? 8'h1F : 8'h00, m);
      n_checks++;
      if (m !== want_m[i]) begin
        n_fail++;
        $display("FAIL oor_read%0d: got %h want %h", i, m, want_m[i]);
      end
    end
    frame_end();
    loc_rd(7'd40, d);
    n_checks++;
    if (d !== 8'hFF) begin n_fail++; $display("FAIL oor_loc_rdata: got %h want FF", d); end
  endtask

  task automatic test_wrap();
    logic [7:0] m, d;
    frame_begin();
    xfer(8'hFF, m);
    xfer(8'h01, m);
    exp_q.push_back({7'd0, 8'h02});
    xfer(8'h02, m);
    frame_end();
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_stb_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap_stb: got (%h,%h) want (%h,%h)", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    loc_rd(7'd0, d);
    n_checks++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL wrap_mem0: got %h want 02", d); end
  endtask

  task automatic test_collision_reset();
    logic [7:0] m, d;
    frame_begin();
    xfer(8'h82, m);
    idle(3);
    bus.dout = 8'h99; bus.request = 1'b1;
    bus.loc_addr = 7'd2; bus.loc_wdata = 8'h77; bus.loc_we = 1'b1;
    exp_q.push_back({7'd2, 8'h99});
    idle(1);
    bus.request = 1'b0; bus.loc_we = 1'b0;
    idle(3);
    bus.dout = 8'h98; bus.request = 1'b1;
    bus.loc_addr = 7'd10; bus.loc_wdata = 8'h44; bus.loc_we = 1'b1;
    exp_q.push_back({7'd3, 8'h98});
    idle(1);
    bus.request = 1'b0; bus.loc_we = 1'b0;
    loc_rd(7'd2, d);
    n_checks++;
    if (d !== 8'h99) begin n_fail++; $display("FAIL collide_mem2: got %h want 99", d); end
    loc_rd(7'd3, d);
    n_checks++;
    if (d !== 8'h98) begin n_fail++; $display("FAIL collide_mem3: got %h want 98", d); end
    loc_rd(7'd10, d);
    n_checks++;
    if (d !== 8'h44) begin n_fail++; $display("FAIL collide_mem10: got %h want 44", d); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL collide_stb_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [14:0] e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL collide_stb: got (%h,%h) want (%h,%h)", o[14:8], o[7:0], e[14:8], e[7:0]);
      end
    end
    exp_q.delete(); obs_q.delete();
    // frame still open: pull reset mid-frame
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.din !== 8'h00 || bus.loc_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL midframe_reset: got busy=%b din=%h rdata=%h want 0/00/00", bus.busy, bus.din, bus.loc_rdata);
    end
    idle(2);
    reset_n = 1'b1;
    idle(2);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", bus.busy); end
    bus.request = 1'b1;
    idle(1);
    bus.request = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_reenter: got %b want 1", bus.busy); end
    frame_end();
    for (int i = 0; i < 3; i++) begin
      logic [6:0] a;
      a = (i == 0) ? 7'd2 : (i == 1) ? 7'd10 : 7'd31;
      loc_rd(a, d);
      n_checks++;
      if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mem%0d: got %h want 00", a, d); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.select = 1'b0; bus.request = 1'b0; bus.dout = 8'h00;
    bus.loc_addr = 7'd0; bus.loc_we = 1'b0; bus.loc_wdata = 8'h00;
    test_reset();
    test_no_select();
    test_write();
    test_read();
    test_out_of_range();
    test_wrap();
    test_collision_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
